// File: rtl/query_sched_if.sv
// query_sched_if: host, tracker and migration-engine handshakes around the query scheduler
interface query_sched_if #(
  parameter int ADDR_SIZE = 28,
  parameter int CMD_WIDTH = 4
);
  logic                 tick_en;
  logic                 host_req_en;
  logic [CMD_WIDTH-1:0] host_req_cmd;
  logic                 host_req_ready;
  logic                 query_en;
  logic [CMD_WIDTH-1:0] query_cmd;
  logic                 query_ready;
  logic                 mig_addr_en;
  logic [ADDR_SIZE-1:0] mig_addr;
  logic                 mig_addr_ready;
  logic                 mig_req_valid;
  logic [ADDR_SIZE-1:0] mig_req_addr;
  logic                 mig_req_ready;
  logic                 busy;
  logic [31:0]          issued_cnt;
  logic [15:0]          drop_cnt;
  logic [15:0]          timeout_cnt;
  modport master (
    output tick_en, host_req_en, host_req_cmd, query_ready, mig_addr_en, mig_addr, mig_req_ready,
    input  host_req_ready, query_en, query_cmd, mig_addr_ready, mig_req_valid, mig_req_addr,
           busy, issued_cnt, drop_cnt, timeout_cnt
  );
  modport slave (
    input  tick_en, host_req_en, host_req_cmd, query_ready, mig_addr_en, mig_addr, mig_req_ready,
    output host_req_ready, query_en, query_cmd, mig_addr_ready, mig_req_valid, mig_req_addr,
           busy, issued_cnt, drop_cnt, timeout_cnt
  );
endinterface

// File: rtl/query_sched.sv
// query_sched: arbitrates rate ticks and host commands onto the tracker query port and buffers returned addresses
module query_sched #(
  parameter int ADDR_SIZE  = 28,
  parameter int CMD_WIDTH  = 4,
  parameter int TOP_K      = 5,
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3,
  parameter int TIMEOUT    = 255
) (
  input logic         clk,
  input logic         rstn,
  query_sched_if.slave bus
);
  localparam int KW = $clog2(TOP_K + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CMD_WIDTH-1:0] CMD_MIG   = CMD_WIDTH'(1);
  localparam logic [CMD_WIDTH-1:0] CMD_FLUSH = CMD_WIDTH'(2);
  typedef enum logic [1:0] {IDLE, ISSUE, COLLECT} state_t;
  state_t               state_q, state_d;
  logic [CMD_WIDTH-1:0] cmd_q, cmd_d, host_cmd_q, host_cmd_d;
  logic                 host_pend_q, host_pend_d, tick_pend_q, tick_pend_d;
  logic [31:0]          issued_cnt_q, issued_cnt_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d, timeout_cnt_q, timeout_cnt_d;
  logic [KW-1:0]        k_q, k_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [ADDR_SIZE-1:0] last_q, last_d;
  logic                 last_vld_q, last_vld_d;
  logic [ADDR_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [ADDR_SIZE-1:0] mem_d [FIFO_DEPTH];
  logic [FIFO_AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                 empty, full, host_acc, take_host, take_tick, query_hs, accept, push, pop;
  assign empty     = wr_ptr_q == rd_ptr_q;
  assign full      = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) && (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign host_acc  = bus.host_req_en && !host_pend_q;
  assign take_host = state_q == IDLE && host_pend_q;
  assign take_tick = state_q == IDLE && !host_pend_q && tick_pend_q;
  assign query_hs  = state_q == ISSUE && bus.query_ready;
  assign accept    = state_q == COLLECT && bus.mig_addr_en && !full;
  assign push      = accept && !(last_vld_q && bus.mig_addr == last_q);
  assign pop       = !empty && bus.mig_req_ready;
  assign bus.host_req_ready = !host_pend_q;
  assign bus.query_en       = state_q == ISSUE;
  assign bus.query_cmd      = state_q == ISSUE ? cmd_q : '0;
  assign bus.mig_addr_ready = state_q == COLLECT && !full;
  assign bus.mig_req_valid  = !empty;
  assign bus.mig_req_addr   = mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign bus.busy           = state_q != IDLE;
  assign bus.issued_cnt     = issued_cnt_q;
  assign bus.drop_cnt       = drop_cnt_q;
  assign bus.timeout_cnt    = timeout_cnt_q;
  // Capture host and tick requests; a tick landing on an unconsumed tick is counted as dropped
  always_comb begin
    host_pend_d = host_acc || (host_pend_q && !take_host);
    host_cmd_d  = host_acc ? bus.host_req_cmd : host_cmd_q;
    tick_pend_d = bus.tick_en || (tick_pend_q && !take_tick);
    drop_cnt_d  = drop_cnt_q + 16'(bus.tick_en && tick_pend_q && !take_tick && drop_cnt_q != 16'hffff);
  end
  // Query FSM: host-first arbitration, held command until handshake, then result collection
  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    k_d           = k_q;
    tmo_d         = tmo_q;
    issued_cnt_d  = issued_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    case (state_q)
      IDLE: begin
        state_d = (take_host || take_tick) ? ISSUE : IDLE;
        cmd_d   = take_host ? host_cmd_q : take_tick ? CMD_MIG : cmd_q;
      end
      ISSUE: if (query_hs) begin
        issued_cnt_d = issued_cnt_q + 32'd1;
        k_d          = '0;
        tmo_d        = '0;
        state_d      = cmd_q == CMD_MIG ? COLLECT : IDLE;
      end
      COLLECT: if (accept) begin
        k_d     = k_q + KW'(1);
        tmo_d   = '0;
        state_d = k_d == KW'(TOP_K) ? IDLE : COLLECT;
      end else begin
        tmo_d         = tmo_q + TW'(1);
        state_d       = tmo_d == TW'(TIMEOUT) ? IDLE : COLLECT;
        timeout_cnt_d = timeout_cnt_q + 16'(tmo_d == TW'(TIMEOUT) && timeout_cnt_q != 16'hffff);
      end
      default: state_d = IDLE;
    endcase
  end
  // Result FIFO with back-to-back duplicate suppression; FLUSH forgets the last address
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q[FIFO_AW-1:0]] = bus.mig_addr;
    wr_ptr_d   = wr_ptr_q + (FIFO_AW + 1)'(push);
    rd_ptr_d   = rd_ptr_q + (FIFO_AW + 1)'(pop);
    last_d     = push ? bus.mig_addr : last_q;
    last_vld_d = push || (last_vld_q && !(query_hs && cmd_q == CMD_FLUSH));
  end
  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      host_cmd_q    <= '0;
      host_pend_q   <= 1'b0;
      tick_pend_q   <= 1'b0;
      issued_cnt_q  <= '0;
      drop_cnt_q    <= '0;
      timeout_cnt_q <= '0;
      k_q           <= '0;
      tmo_q         <= '0;
      last_q        <= '0;
      last_vld_q    <= 1'b0;
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      host_cmd_q    <= host_cmd_d;
      host_pend_q   <= host_pend_d;
      tick_pend_q   <= tick_pend_d;
      issued_cnt_q  <= issued_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      k_q           <= k_d;
      tmo_q         <= tmo_d;
      last_q        <= last_d;
      last_vld_q    <= last_vld_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end
endmodule

// File: tb/tb_query_sched.sv
// tb_query_sched: vector table, directed corner sequences and randomized traffic against a queue-based model
module tb_query_sched;
  localparam int AW = 28;
  localparam int CW = 4;
  typedef struct {
    logic          tick;
    logic [CW-1:0] cmd;
    int            dly;
    logic [CW-1:0] exp_cmd;
    logic          collects;
  } vec_t;
  logic clk = 0, rstn = 0;
  logic rand_rdy = 0, rnd_bit = 0, man_rdy = 1;
  int n_chk = 0, n_fail = 0, exp_issued = 0;
  logic [AW-1:0] got_q[$], exp_q[$];
  logic [AW-1:0] m_last = '0;
  logic m_lv = 0;
  vec_t tbl[6];
  query_sched_if #(.ADDR_SIZE(AW), .CMD_WIDTH(CW)) bus();
  query_sched dut (.clk(clk), .rstn(rstn), .bus(bus));
  assign bus.mig_req_ready = rand_rdy ? rnd_bit : man_rdy;
  always #5 clk = ~clk;
  always begin
    @(posedge clk);
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end
  always @(negedge clk) if (rstn && bus.mig_req_valid && bus.mig_req_ready) got_q.push_back(bus.mig_req_addr);
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  // Reference rule: an accepted address is delivered unless it repeats the previously delivered one
  function automatic void model_push(input logic [AW-1:0] a);
    if (!(m_lv && a == m_last)) exp_q.push_back(a);
    m_last = a;
    m_lv = 1;
  endfunction
  task automatic wait_qen(input logic [CW-1:0] exp_cmd);
    int t = 0;
    @(negedge clk);
    while (!bus.query_en && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("query_en_seen", bus.query_en, 1);
    chk("query_cmd", bus.query_cmd, exp_cmd);
  endtask
  task automatic hs(input logic [CW-1:0] exp_cmd, input int dly);
    repeat (dly) begin
      @(posedge clk);
      @(negedge clk);
      chk("query_en_hold", bus.query_en, 1);
      chk("query_cmd_hold", bus.query_cmd, exp_cmd);
    end
    bus.query_ready = 1;
    @(posedge clk);
    #1 bus.query_ready = 0;
    exp_issued++;
    if (exp_cmd == 2) m_lv = 0;
  endtask
  task automatic do_query(input logic [CW-1:0] exp_cmd, input int dly);
    wait_qen(exp_cmd);
    hs(exp_cmd, dly);
  endtask
  task automatic send_addr(input logic [AW-1:0] a);
    int t = 0;
    bus.mig_addr_en = 1;
    bus.mig_addr = a;
    @(negedge clk);
    while (!bus.mig_addr_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("mig_addr_ready_seen", bus.mig_addr_ready, 1);
    @(posedge clk);
    #1 bus.mig_addr_en = 0;
  endtask
  task automatic pulse_tick();
    bus.tick_en = 1;
    cyc();
    bus.tick_en = 0;
  endtask
  task automatic cmp_out(input string nm);
    int t = 0;
    while (got_q.size() < exp_q.size() && t < 3000) begin
      cyc();
      t++;
    end
    chk({nm, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk(nm, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask
  initial begin
    logic [AW-1:0] a;
    logic [CW-1:0] c;
    tbl[0] = '{tick: 1, cmd: 0,  dly: 1, exp_cmd: 1,  collects: 1};
    tbl[1] = '{tick: 0, cmd: 2,  dly: 0, exp_cmd: 2,  collects: 0};
    tbl[2] = '{tick: 0, cmd: 0,  dly: 2, exp_cmd: 0,  collects: 0};
    tbl[3] = '{tick: 0, cmd: 1,  dly: 0, exp_cmd: 1,  collects: 1};
    tbl[4] = '{tick: 0, cmd: 3,  dly: 1, exp_cmd: 3,  collects: 0};
    tbl[5] = '{tick: 0, cmd: 15, dly: 0, exp_cmd: 15, collects: 0};
    bus.tick_en = 0;
    bus.host_req_en = 0;
    bus.host_req_cmd = 0;
    bus.query_ready = 0;
    bus.mig_addr_en = 0;
    bus.mig_addr = 0;
    repeat (3) cyc();
    chk("rst_query_en", bus.query_en, 0);
    chk("rst_query_cmd", bus.query_cmd, 0);
    chk("rst_mig_req_valid", bus.mig_req_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_host_req_ready", bus.host_req_ready, 1);
    chk("rst_mig_addr_ready", bus.mig_addr_ready, 0);
    chk("rst_issued_cnt", bus.issued_cnt, 0);
    rstn = 1;
    cyc();
    // Single tick, late query_ready, five distinct addresses
    pulse_tick();
    @(negedge clk);
    chk("tick_lat_early", bus.query_en, 0);
    @(negedge clk);
    chk("tick_lat", bus.query_en, 1);
    chk("tick_cmd", bus.query_cmd, 1);
    hs(1, 3);
    chk("issued_after_t1", bus.issued_cnt, exp_issued);
    for (int j = 0; j < 5; j++) begin
      a = 28'h0001000 + AW'(j);
      model_push(a);
      send_addr(a);
      chk("t1_busy", bus.busy, j < 4);
    end
    cmp_out("t1_out");
    // Tick and host FLUSH in the same cycle: host first, no collection, then the MIG
    bus.tick_en = 1;
    bus.host_req_en = 1;
    bus.host_req_cmd = 2;
    cyc();
    bus.tick_en = 0;
    bus.host_req_en = 0;
    wait_qen(2);
    hs(2, 0);
    chk("flush_no_collect", bus.busy, 0);
    do_query(1, 0);
    for (int j = 0; j < 5; j++) begin
      a = 28'h0002000 + AW'(j);
      model_push(a);
      send_addr(a);
    end
    chk("issued_after_t2", bus.issued_cnt, exp_issued);
    cmp_out("t2_out");
    // Stalled migration engine: FIFO fills at eight and back-pressures the tracker
    man_rdy = 0;
    pulse_tick();
    do_query(1, 0);
    a = 28'h0003000;
    model_push(a);
    send_addr(a);
    @(negedge clk);
    chk("valid_latency", bus.mig_req_valid, 1);
    chk("head_addr", bus.mig_req_addr, 28'h0003000);
    cyc();
    for (int j = 1; j < 5; j++) begin
      a = 28'h0003000 + AW'(j);
      model_push(a);
      send_addr(a);
    end
    pulse_tick();
    do_query(1, 0);
    for (int j = 5; j < 8; j++) begin
      a = 28'h0003000 + AW'(j);
      model_push(a);
      send_addr(a);
    end
    bus.mig_addr_en = 1;
    bus.mig_addr = 28'h0003008;
    repeat (3) begin
      @(negedge clk);
      chk("full_holdoff", bus.mig_addr_ready, 0);
      chk("full_busy", bus.busy, 1);
    end
    @(posedge clk);
    #1 man_rdy = 1;
    for (int j = 8; j < 10; j++) begin
      a = 28'h0003000 + AW'(j);
      model_push(a);
      send_addr(a);
    end
    cmp_out("t3_out");
    // Tracker stalls after two addresses: collection times out
    chk("timeout_before", bus.timeout_cnt, 0);
    pulse_tick();
    do_query(1, 0);
    for (int j = 0; j < 2; j++) begin
      a = 28'h0004000 + AW'(j);
      model_push(a);
      send_addr(a);
    end
    repeat (254) cyc();
    chk("timeout_not_yet", bus.busy, 1);
    cyc();
    chk("timeout_exit", bus.busy, 0);
    chk("timeout_cnt", bus.timeout_cnt, 1);
    cmp_out("t4_out");
    // Ticks while ISSUE is stalled, then a duplicate in the result stream
    pulse_tick();
    wait_qen(1);
    @(posedge clk);
    #1 bus.tick_en = 1;
    repeat (3) cyc();
    bus.tick_en = 0;
    @(negedge clk);
    chk("drop_cnt", bus.drop_cnt, 2);
    chk("issue_held", bus.query_en, 1);
    hs(1, 0);
    a = 28'h0005000;
    model_push(a);
    send_addr(a);
    model_push(a);
    send_addr(a);
    a = 28'h0005001;
    model_push(a);
    send_addr(a);
    chk("dup_counts_k", bus.busy, 1);
    for (int j = 2; j < 4; j++) begin
      a = 28'h0005000 + AW'(j);
      model_push(a);
      send_addr(a);
    end
    chk("dup_exit", bus.busy, 0);
    chk("dup_exp_len", exp_q.size(), 4);
    do_query(1, 0);
    for (int j = 0; j < 5; j++) begin
      a = 28'h0005100 + AW'(j);
      model_push(a);
      send_addr(a);
    end
    cmp_out("t5_out");
    // Vector table: one command per row
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].tick) bus.tick_en = 1;
      else begin
        bus.host_req_en = 1;
        bus.host_req_cmd = tbl[i].cmd;
      end
      cyc();
      bus.tick_en = 0;
      bus.host_req_en = 0;
      chk("tbl_host_ready", bus.host_req_ready, tbl[i].tick);
      do_query(tbl[i].exp_cmd, tbl[i].dly);
      chk("tbl_collect", bus.busy, tbl[i].collects);
      if (tbl[i].collects)
        for (int j = 0; j < 5; j++) begin
          a = 28'h0006000 + AW'(i * 16 + j);
          model_push(a);
          send_addr(a);
        end
    end
    chk("tbl_issued", bus.issued_cnt, exp_issued);
    cmp_out("tbl_out");
    // Randomized commands, small address pool for duplicates, random downstream ready
    rand_rdy = 1;
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        c = 1;
        pulse_tick();
      end else begin
        c = CW'($urandom_range(0, 2));
        bus.host_req_en = 1;
        bus.host_req_cmd = c;
        cyc();
        bus.host_req_en = 0;
      end
      do_query(c, $urandom_range(0, 3));
      if (c == 1)
        for (int j = 0; j < 5; j++) begin
          a = 28'h0ABC000 + AW'($urandom_range(0, 2));
          model_push(a);
          send_addr(a);
        end
    end
    rand_rdy = 0;
    man_rdy = 1;
    cmp_out("rand_out");
    chk("rand_issued", bus.issued_cnt, exp_issued);
    chk("rand_drop", bus.drop_cnt, 2);
    // Reset in COLLECT with three buffered addresses
    man_rdy = 0;
    pulse_tick();
    do_query(1, 0);
    for (int j = 0; j < 3; j++) send_addr(28'h0007000 + AW'(j));
    chk("pre_rst_busy", bus.busy, 1);
    chk("pre_rst_valid", bus.mig_req_valid, 1);
    rstn = 0;
    cyc();
    rstn = 1;
    chk("mid_rst_valid", bus.mig_req_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_issued", bus.issued_cnt, 0);
    chk("mid_rst_drop", bus.drop_cnt, 0);
    chk("mid_rst_timeout", bus.timeout_cnt, 0);
    chk("mid_rst_host_ready", bus.host_req_ready, 1);
    chk("mid_rst_query_en", bus.query_en, 0);
    man_rdy = 1;
    repeat (5) cyc();
    chk("mid_rst_discard", got_q.size(), 0);
    chk("mid_rst_idle", bus.busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
